serial_add_seq: RTL and testbench



---
 rtl/serial_add_seq.sv | 132 +++++++++++++
 tb/tb_serial_add_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// Multi-cycle WIDTH-bit adder: a single 2-bit ripple-carry slice is stepped over the
// operands, least-significant pair first, with the inter-slice carry held in a register.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             ABORT,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY
);

  localparam int unsigned NumSlices = WIDTH / 2;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : gen_width_check
    $error("serial_add_seq: WIDTH must be even and >= 2");
  end

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [1:0] slice_a, slice_b, slice_sum;
  logic       slice_mid, slice_cout;

  // Operand pair selected by the slice counter.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NumSlices; i++) begin
      if (cnt_q == CntW'(i)) begin
        slice_a = a_q[2*i +: 2];
        slice_b = b_q[2*i +: 2];
      end
    end
  end

  // Two-bit ripple-carry cell.
  always_comb begin
    slice_sum[0] = slice_a[0] ^ slice_b[0] ^ carry_q;
    slice_mid    = (slice_a[0] & slice_b[0]) | (slice_a[0] & carry_q) | (slice_b[0] & carry_q);
    slice_sum[1] = slice_a[1] ^ slice_b[1] ^ slice_mid;
    slice_cout   = (slice_a[1] & slice_b[1]) | (slice_a[1] & slice_mid) |
                   (slice_b[1] & slice_mid);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        // ABORT blocks a simultaneous accept.
        if (I_VALID && !ABORT) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (ABORT) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          for (int unsigned i = 0; i < NumSlices; i++) begin
            if (cnt_q == CntW'(i)) res_d[2*i +: 2] = slice_sum;
          end
          carry_d = slice_cout;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (O_READY || ABORT) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign I_READY = (state_q == StIdle);
  assign BUSY    = (state_q != StIdle);
  assign O_VALID = (state_q == StDone);
  assign O       = res_q;
  assign COUT    = carry_q;
  assign OVF     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: vector table and random adds checked through a result
// scoreboard, plus hand sequences for backpressure, abort, async reset and a WIDTH=2 build.
module tb_serial_add_seq;

  logic       CLK, ASYNCRESETN;
  logic       I_VALID, I_READY, CIN, ABORT, O_VALID, O_READY, COUT, OVF, BUSY;
  logic [7:0] A, B, O;

  logic       w2_i_valid, w2_i_ready, w2_cin, w2_abort, w2_o_valid, w2_o_ready;
  logic       w2_cout, w2_ovf, w2_busy;
  logic [1:0] w2_a, w2_b, w2_o;

  serial_add_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_VALID(I_VALID), .I_READY(I_READY),
    .A(A), .B(B), .CIN(CIN), .ABORT(ABORT), .O_VALID(O_VALID), .O_READY(O_READY),
    .O(O), .COUT(COUT), .OVF(OVF), .BUSY(BUSY)
  );

  serial_add_seq #(.WIDTH(2)) dut_w2 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I_VALID(w2_i_valid), .I_READY(w2_i_ready),
    .A(w2_a), .B(w2_b), .CIN(w2_cin), .ABORT(w2_abort), .O_VALID(w2_o_valid),
    .O_READY(w2_o_ready), .O(w2_o), .COUT(w2_cout), .OVF(w2_ovf), .BUSY(w2_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [7:0] o;
    logic       cout;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    res_t       exp;
  } vec_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] s;
    res_t r;
    s      = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    r.o    = s[7:0];
    r.cout = s[8];
    r.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
    return r;
  endfunction

  // Scoreboard: a result is consumed on any edge that sees O_VALID & O_READY without ABORT.
  always @(negedge CLK) begin
    res_t e;
    if (ASYNCRESETN && O_VALID && O_READY && !ABORT) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got O=%0h with nothing pending, expected no result", O);
      end else begin
        e = sb.pop_front();
        check("sum", O, e.o);
        check("cout", COUT, e.cout);
        check("ovf", OVF, e.ovf);
      end
    end
  end

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input bit push, input res_t exp);
    int t;
    t = 0;
    while (!I_READY && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    check("ready_before_accept", I_READY, 1);
    A = a; B = b; CIN = cin; I_VALID = 1'b1;
    @(posedge CLK);
    if (push) sb.push_back(exp);
    #1;
    I_VALID = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input res_t exp);
    int lat, busy_n, edges;
    accept(a, b, cin, 1'b1, exp);
    lat = -1; busy_n = 0; edges = 0;
    while (BUSY && edges < 30) begin
      busy_n++;
      if (O_VALID && lat < 0) lat = edges;
      @(posedge CLK); #1;
      edges++;
    end
    check("latency", lat, 4);
    check("busy_cycles", busy_n, 5);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (BUSY && t < 40) begin
      @(posedge CLK); #1;
      t++;
    end
    check("idle_timeout", BUSY, 0);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!O_VALID && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    check("valid_timeout", O_VALID, 1);
  endtask

  vec_t vecs[10];
  res_t none;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, '{8'h96, 1'b0, 1'b1}};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0}};
    vecs[3] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}};
    vecs[4] = '{8'h7F, 8'h7F, 1'b1, '{8'hFF, 1'b0, 1'b1}};
    vecs[5] = '{8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0}};
    vecs[6] = '{8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0}};
    vecs[7] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0}};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, '{8'h00, 1'b1, 1'b0}};
    vecs[9] = '{8'hC0, 8'hC0, 1'b0, '{8'h80, 1'b1, 1'b0}};
    none = '{8'h00, 1'b0, 1'b0};

    ASYNCRESETN = 1'b0;
    I_VALID = 1'b0; A = '0; B = '0; CIN = 1'b0; ABORT = 1'b0; O_READY = 1'b1;
    w2_i_valid = 1'b0; w2_a = '0; w2_b = '0; w2_cin = 1'b0; w2_abort = 1'b0;
    w2_o_ready = 1'b1;

    #2;
    check("rst_i_ready", I_READY, 1);
    check("rst_o_valid", O_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_o", O, 0);
    check("rst_cout", COUT, 0);
    check("rst_ovf", OVF, 0);
    check("rst_w2_i_ready", w2_i_ready, 1);
    #10 ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, model(ra, rb, rc));
    end

    // Backpressure: result held, new request waits until the edge after the handshake.
    O_READY = 1'b0;
    accept(8'h12, 8'h34, 1'b0, 1'b1, '{8'h46, 1'b0, 1'b0});
    I_VALID = 1'b1; A = 8'h21; B = 8'h43; CIN = 1'b0;
    check("bp_ready_run", I_READY, 0);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_o", O, 8'h46);
      check("bp_hold_cout", COUT, 0);
      check("bp_hold_ovf", OVF, 0);
      check("bp_hold_ready", I_READY, 0);
      check("bp_hold_valid", O_VALID, 1);
      @(posedge CLK); #1;
    end
    O_READY = 1'b1;
    @(posedge CLK); #1;
    check("bp_idle_after_hs", BUSY, 0);
    check("bp_ready_after_hs", I_READY, 1);
    sb.push_back(model(8'h21, 8'h43, 1'b0));
    @(posedge CLK); #1;
    check("bp_second_accept", BUSY, 1);
    I_VALID = 1'b0;
    wait_idle();

    // ABORT in the second RUN cycle.
    accept(8'h10, 8'h20, 1'b0, 1'b0, none);
    @(posedge CLK); #1;
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    check("abort_run_busy", BUSY, 0);
    check("abort_run_ready", I_READY, 1);
    check("abort_run_valid", O_VALID, 0);
    repeat (5) @(posedge CLK);
    #1;
    check("abort_run_no_valid", O_VALID, 0);
    run_op(8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0});

    // ABORT in IDLE beats I_VALID.
    ABORT = 1'b1; I_VALID = 1'b1; A = 8'h0F; B = 8'h0F;
    @(posedge CLK); #1;
    check("abort_idle_no_accept", BUSY, 0);
    ABORT = 1'b0; I_VALID = 1'b0;

    // ABORT together with O_READY in DONE drops the result.
    O_READY = 1'b0;
    accept(8'h33, 8'h44, 1'b0, 1'b0, none);
    wait_valid();
    check("abort_done_o", O, 8'h77);
    ABORT = 1'b1; O_READY = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    check("abort_done_busy", BUSY, 0);
    check("abort_done_valid", O_VALID, 0);

    // WIDTH=2 build: 3 + 1 + 1.
    w2_a = 2'h3; w2_b = 2'h1; w2_cin = 1'b1; w2_i_valid = 1'b1;
    @(posedge CLK); #1;
    w2_i_valid = 1'b0;
    check("w2_busy", w2_busy, 1);
    check("w2_valid_early", w2_o_valid, 0);
    @(posedge CLK); #1;
    check("w2_valid", w2_o_valid, 1);
    check("w2_o", w2_o, 2'h1);
    check("w2_cout", w2_cout, 1);
    check("w2_ovf", w2_ovf, 0);
    @(posedge CLK); #1;
    check("w2_idle", w2_busy, 0);

    // Async reset between edges mid-RUN.
    accept(8'h55, 8'h66, 1'b1, 1'b0, none);
    @(posedge CLK); #1;
    #2 ASYNCRESETN = 1'b0;
    #1;
    check("arst_o", O, 0);
    check("arst_cout", COUT, 0);
    check("arst_ovf", OVF, 0);
    check("arst_valid", O_VALID, 0);
    check("arst_busy", BUSY, 0);
    check("arst_ready", I_READY, 1);
    @(negedge CLK); #2;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    check("arst_ready_after", I_READY, 1);
    check("arst_busy_after", BUSY, 0);
    repeat (6) @(posedge CLK);
    #1;
    check("arst_no_result", O_VALID, 0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
